// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, control-bundle bit map and
// helpers that say which source registers an opcode actually reads.
package riscv_pkg;

    localparam int CTRL_W = 10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    // Control bundle bit positions; ALU_OP occupies two bits starting at ALU_OP.
    localparam int REG_WRITE  = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int MEM_TO_REG = 3;
    localparam int ALU_SRC    = 4;
    localparam int BRANCH     = 5;
    localparam int JUMP       = 6;
    localparam int ALU_OP     = 7;
    localparam int ALU_OP_W   = 2;
    localparam int SPARE      = 9;

    function automatic logic usesRs1(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_RTYPE: usesRs1 = 1'b1;
            default:                                        usesRs1 = 1'b0;
        endcase
    endfunction

    function automatic logic usesRs2(input logic [6:0] opcode);
        case (opcode)
            OP_STORE, OP_BRANCH, OP_RTYPE: usesRs2 = 1'b1;
            default:                       usesRs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Combinational load-use detector: a load in EX whose rd is actually read by
// the valid instruction in ID. Writes to x0 never create a dependency.
module hazard_detect (
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        hazard
);
    import riscv_pkg::*;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1Match;
    logic       rs2Match;
    logic       unusedInstrBits;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];
    assign unusedInstrBits = ^{id_instr[31:25], id_instr[14:7]};

    assign rs1Match = usesRs1(opcode) && (rs1 == ex_rd);
    assign rs2Match = usesRs2(opcode) && (rs2 == ex_rd);

    assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    id_valid && (rs1Match || rs2Match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush and load-use bubble insertion.
// Hazard detection and the bubble counter exist only with LOAD_USE_DETECT_EN.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       stall_count
);
    import riscv_pkg::*;

    logic              exValid_q,   exValid_d;
    logic [XLEN-1:0]   exPc_q,      exPc_d;
    logic [XLEN-1:0]   exImm_q,     exImm_d;
    logic [XLEN-1:0]   exRs1Data_q, exRs1Data_d;
    logic [XLEN-1:0]   exRs2Data_q, exRs2Data_d;
    logic [4:0]        exRd_q,      exRd_d;
    logic [4:0]        exRs1_q,     exRs1_d;
    logic [4:0]        exRs2_q,     exRs2_d;
    logic [CTRL_W-1:0] exCtrl_q,    exCtrl_d;
    logic              loadUseHazard;
    logic              unusedInstrBits;

    assign unusedInstrBits = ^{id_instr[31:25], id_instr[14:12], id_instr[6:0]};

`ifdef LOAD_USE_DETECT_EN
    logic [31:0] stallCount_q, stallCount_d;

    hazard_detect u_hazard (
        .ex_valid    (exValid_q),
        .ex_mem_read (exCtrl_q[MEM_READ]),
        .ex_rd       (exRd_q),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .hazard      (loadUseHazard)
    );

    // A flush outranks the hazard, so a wrong-path stall is never counted.
    always_comb begin
        stallCount_d = stallCount_q;
        if (!ex_flush && loadUseHazard && (stallCount_q != 32'hFFFF_FFFF)) begin
            stallCount_d = stallCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign stall_count = stallCount_q;
`else
    assign loadUseHazard = 1'b0;
    assign stall_count   = '0;
`endif

    assign hazard_stall = !rst && !ex_flush && loadUseHazard;

    always_comb begin
        exValid_d   = 1'b0;
        exPc_d      = '0;
        exImm_d     = '0;
        exRs1Data_d = '0;
        exRs2Data_d = '0;
        exRd_d      = '0;
        exRs1_d     = '0;
        exRs2_d     = '0;
        exCtrl_d    = '0;
        if (!ex_flush && !loadUseHazard) begin
            exValid_d   = id_valid;
            exPc_d      = id_pc;
            exImm_d     = id_imm;
            exRs1Data_d = id_rs1_data;
            exRs2Data_d = id_rs2_data;
            exRd_d      = id_instr[11:7];
            exRs1_d     = id_instr[19:15];
            exRs2_d     = id_instr[24:20];
            exCtrl_d    = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q   <= 1'b0;
            exPc_q      <= '0;
            exImm_q     <= '0;
            exRs1Data_q <= '0;
            exRs2Data_q <= '0;
            exRd_q      <= '0;
            exRs1_q     <= '0;
            exRs2_q     <= '0;
            exCtrl_q    <= '0;
        end else begin
            exValid_q   <= exValid_d;
            exPc_q      <= exPc_d;
            exImm_q     <= exImm_d;
            exRs1Data_q <= exRs1Data_d;
            exRs2Data_q <= exRs2Data_d;
            exRd_q      <= exRd_d;
            exRs1_q     <= exRs1_d;
            exRs2_q     <= exRs2_d;
            exCtrl_q    <= exCtrl_d;
        end
    end

    assign ex_valid    = exValid_q;
    assign ex_pc       = exPc_q;
    assign ex_imm      = exImm_q;
    assign ex_rs1_data = exRs1Data_q;
    assign ex_rs2_data = exRs2Data_q;
    assign ex_rd       = exRd_q;
    assign ex_rs1      = exRs1_q;
    assign ex_rs2      = exRs2_q;
    assign ex_ctrl     = exCtrl_q;

endmodule
